// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver with a small scancode FIFO and sticky error flags.
// Define PS2_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES clocks without a ps2Clk edge.
module ps2_receiver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    input  logic       rdStrobe,
    input  logic       clrErr,
    output logic [7:0] data,
    output logic       dataValid,
    output logic       overflow,
    output logic       parityError,
    output logic       frameError,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, CHECK = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic          stop_q, stop_d;
    logic          overflow_q, overflow_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
    logic ps2_data_s1_q, ps2_data_s2_q;
    logic fe, timeout_hit;
    logic in_check, parity_ok, push, pop, wr_en, full, empty;

    // Synchronizers idle high so a reset never manufactures a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2_clk_s1_q   <= 1'b1;
            ps2_clk_s2_q   <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_data_s1_q  <= 1'b1;
            ps2_data_s2_q  <= 1'b1;
        end else begin
            ps2_clk_s1_q   <= ps2Clk;
            ps2_clk_s2_q   <= ps2_clk_s1_q;
            ps2_clk_prev_q <= ps2_clk_s2_q;
            ps2_data_s1_q  <= ps2Data;
            ps2_data_s2_q  <= ps2_data_s1_q;
        end
    end

    assign fe = ps2_clk_prev_q & ~ps2_clk_s2_q;

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    assign timeout_hit = (state_q == RECV) && !fe && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        idle_cnt_d = '0;
        if (state_q == RECV && !fe && !timeout_hit) begin
            idle_cnt_d = idle_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) idle_cnt_q <= '0;
        else       idle_cnt_q <= idle_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register plus frame and FIFO bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            stop_q       <= 1'b0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            stop_q       <= stop_d;
            overflow_q   <= overflow_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fe && !ps2_data_s2_q) state_d = RECV;
            RECV: begin
                if (timeout_hit)                    state_d = IDLE;
                else if (fe && bit_cnt_q == 4'd10)  state_d = CHECK;
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        stop_d    = stop_q;
        case (state_q)
            IDLE:    bit_cnt_d = (fe && !ps2_data_s2_q) ? 4'd1 : 4'd0;
            RECV: begin
                if (fe) begin
                    // Right shift lands the first (LSB) data bit in bit 0 after eight edges.
                    if (bit_cnt_q <= 4'd8)       shift_d  = {ps2_data_s2_q, shift_q[7:1]};
                    else if (bit_cnt_q == 4'd9)  parity_d = ps2_data_s2_q;
                    else                         stop_d   = ps2_data_s2_q;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: bit_cnt_d = 4'd0;
        endcase
    end

    assign in_check  = (state_q == CHECK);
    assign parity_ok = ^{shift_q, parity_q};
    assign push      = in_check && parity_ok && stop_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop       = rdStrobe && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign wr_en     = push && (!full || pop);

    always_comb begin
        wr_ptr_d     = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        overflow_d   = (push && full && !pop)         | (overflow_q   & ~clrErr);
        parity_err_d = (in_check && !parity_ok)       | (parity_err_q & ~clrErr);
        frame_err_d  = (in_check && !stop_q) | timeout_hit | (frame_err_q & ~clrErr);
    end

    always_comb begin
        data        = empty ? 8'h00 : fifo_mem[rd_ptr_q[AW-1:0]];
        dataValid   = !empty;
        overflow    = overflow_q;
        parityError = parity_err_q;
        frameError  = frame_err_q;
        busy        = (state_q != IDLE);
    end
endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: frame decode, FIFO order/overflow, error flags, timeout, reset.
module tb_ps2_receiver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic       rdStrobe = 1'b0;
  logic       clrErr = 1'b0;
  logic [7:0] data;
  logic       dataValid, overflow, parityError, frameError, busy;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  ps2_receiver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .rdStrobe(rdStrobe), .clrErr(clrErr), .data(data), .dataValid(dataValid),
    .overflow(overflow), .parityError(parityError), .frameError(frameError), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2Data = b;
    repeat (10) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Stop bit is driven inline so the CHECK cycle (3 edges after ps2Clk drops) can be probed.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit chk_lat, input bit pop_at_chk, input bit clr_at_chk);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2Data = stop;
    repeat (10) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (3) @(negedge clk);
    if (chk_lat) check("lat_not_yet", dataValid, 1'b0);
    if (pop_at_chk) rdStrobe = 1'b1;
    if (clr_at_chk) clrErr = 1'b1;
    @(negedge clk);
    rdStrobe = 1'b0;
    clrErr = 1'b0;
    if (chk_lat) begin
      check("lat_valid", dataValid, 1'b1);
      check("lat_data", data, d);
    end
    repeat (16) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (10) @(negedge clk);
    ps2Data = 1'b1;
  endtask

  task automatic good(input logic [7:0] d);
    send_frame(d, ~^d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    rdStrobe = 1'b1;
    @(negedge clk);
    rdStrobe = 1'b0;
  endtask

  task automatic clr();
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
  endtask

  task automatic pop_expect(input string tag);
    logic [7:0] exp;
    exp = exp_q.pop_front();
    check({tag, "_valid"}, dataValid, 1'b1);
    check(tag, data, exp);
    pop();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_data", data, 8'h00);
    check("rst_valid", dataValid, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_perr", parityError, 1'b0);
    check("rst_ferr", frameError, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Falling edge with data high in IDLE is not a start bit; pop on empty is ignored.
    ps2_bit(1'b1);
    check("spur_busy", busy, 1'b0);
    pop();
    check("empty_pop_valid", dataValid, 1'b0);

    // 0x1C has three ones, so odd parity bit is 0.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t1_perr", parityError, 1'b0);
    check("t1_ferr", frameError, 1'b0);
    check("t1_ovf", overflow, 1'b0);
    pop();
    check("t1_valid_after_pop", dataValid, 1'b0);
    check("t1_data_after_pop", data, 8'h00);

    // Ordering: 0xF0 (parity 1) then 0x1C.
    good(8'hF0); exp_q.push_back(8'hF0);
    good(8'h1C); exp_q.push_back(8'h1C);
    pop_expect("t2_head0");
    pop_expect("t2_head1");
    check("t2_empty", dataValid, 1'b0);

    // Bad parity.
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_perr", parityError, 1'b1);
    check("t3_ferr", frameError, 1'b0);
    check("t3_valid", dataValid, 1'b0);
    clr();
    check("t3_perr_clr", parityError, 1'b0);

    // Bad stop with good parity (0x33 has four ones -> parity 1).
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3b_ferr", frameError, 1'b1);
    check("t3b_perr", parityError, 1'b0);
    check("t3b_valid", dataValid, 1'b0);
    // Bad parity with clrErr in the CHECK cycle: new set wins, older frameError clears.
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t3c_perr_setwins", parityError, 1'b1);
    check("t3c_ferr_cleared", frameError, 1'b0);
    // Both parity and stop bad.
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3d_perr", parityError, 1'b1);
    check("t3d_ferr", frameError, 1'b1);
    check("t3d_valid", dataValid, 1'b0);
    clr();
    check("t3d_perr_clr", parityError, 1'b0);
    check("t3d_ferr_clr", frameError, 1'b0);

    // Overflow: fifth byte dropped.
    for (int i = 1; i <= 5; i++) begin
      good(8'(i));
      if (i <= 4) exp_q.push_back(8'(i));
    end
    check("t4_ovf", overflow, 1'b1);
    for (int i = 0; i < 4; i++) pop_expect("t4_pop");
    check("t4_empty", dataValid, 1'b0);
    clr();
    check("t4_ovf_clr", overflow, 1'b0);

    // Push and pop in the same cycle while full: both happen, no overflow.
    for (int i = 0; i < 4; i++) good(8'h11 + 8'(i));
    send_frame(8'h15, ~^8'h15, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t4b_ovf", overflow, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h12 + 8'(i));
    for (int i = 0; i < 4; i++) pop_expect("t4b_pop");
    check("t4b_empty", dataValid, 1'b0);

    // Partial frame: start plus 4 bits, then ps2Clk held high.
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    check("t5_busy_partial", busy, 1'b1);
`ifdef PS2_TIMEOUT_EN
    // 30 edges already elapsed since the last drop; abort lands 1003 edges after it.
    repeat (972) @(negedge clk);
    check("t5_busy_before_to", busy, 1'b1);
    @(negedge clk);
    check("t5_busy_after_to", busy, 1'b0);
    check("t5_ferr_to", frameError, 1'b1);
    clr();
`else
    repeat (1100) @(negedge clk);
    check("t5_busy_waits", busy, 1'b1);
    check("t5_ferr_none", frameError, 1'b0);
    pulse_reset();
`endif
    good(8'h5A); exp_q.push_back(8'h5A);
    pop_expect("t5_5a");
    check("t5_ferr_final", frameError, 1'b0);

    // Reset mid-frame after five data bits of 0x00; leave a byte and a flag pending first.
    good(8'h42);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    reset = 1'b1;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", dataValid, 1'b0);
    check("t6_rst_data", data, 8'h00);
    check("t6_rst_perr", parityError, 1'b0);
    check("t6_rst_ferr", frameError, 1'b0);
    check("t6_rst_ovf", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    // d5=0 becomes a start bit; d6,d7,par,stop and six idle-high bits realign to 0xFC.
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    for (int i = 0; i < 6; i++) ps2_bit(1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_perr", parityError, 1'b0);
    check("t6_ferr", frameError, 1'b0);
    exp_q.push_back(8'hFC);
    pop_expect("t6_realign");
    check("t6_empty", dataValid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
- Consumes the debounced ps2Clk/ps2Data pair and decodes 11-bit PS/2 device-to-host frames: start, 8 data bits LSB first, odd parity, stop.
- Validated scancode bytes go into a small FIFO that the SoC keyboard port reads with a one-cycle pop strobe.
- Sits between the PS/2 debouncer and the SoC I/O logic; runs in the SoC clock domain.

Parameters:
FIFO_DEPTH, 4, scancode FIFO entries; power of two, 2..16
TIMEOUT_CYCLES, 20000, clk cycles without a ps2Clk falling edge before a partial frame is aborted

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
ps2Clk  input  1  debounced PS/2 clock; asynchronous to clk
ps2Data  input  1  debounced PS/2 data; asynchronous to clk
rdStrobe  input  1  pop the FIFO head; single-cycle pulse
clrErr  input  1  clears overflow, parityError and frameError
data  output  8  FIFO head byte; 0x00 when empty
dataValid  output  1  FIFO not empty
overflow  output  1  sticky: a good byte was dropped because the FIFO was full
parityError  output  1  sticky: a frame failed the odd-parity check
frameError  output  1  sticky: bad stop bit, or timeout abort
busy  output  1  a frame is in progress (state != IDLE)

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset state: every output is 0, FSM is IDLE, FIFO is empty, counters are 0, and the synchronizer flops are 1. Reset asserted mid-frame discards the partial frame. No error flag is set by the reset.
- Input sync: each input passes through 2 FFs. A falling edge (fe) is synced clock prev=1 and cur=0, so fe fires 3 clk cycles after the raw input falls. Data is sampled from synced ps2Data in the fe cycle.
- FSM IDLE:
  - fe with data=0: go to RECV, bitCnt=1.
  - fe with data=1: ignore (spurious edge) and stay IDLE.
- FSM RECV:
  - Each fe shifts one bit. bitCnt 1..8 are data bits into shift[7:0], LSB first. bitCnt 9 is the parity bit. bitCnt 10 is the stop bit, then go to CHECK.
  - Idle counter resets on every fe and increments otherwise.
- FSM CHECK (one cycle):
  - Parity OK (popcount(data)+parity is odd) and stop=1: push the byte.
  - Parity bad: set parityError and do not push.
  - Stop=0: set frameError and do not push. If both parity and stop are bad, set both flags.
  - Always return to IDLE.
- Latency: the byte appears on data/dataValid 2 clk cycles after the stop-bit fe (fe cycle N, CHECK at N+1, visible at N+2).
- FIFO:
  - Head is shown combinationally on data. Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap.
  - rdStrobe with dataValid=1 pops at the clock edge. rdStrobe while empty is ignored.
  - Push while full: the byte is dropped, overflow is set, and contents are unchanged.
  - Push and pop in the same cycle while full: both happen, no overflow. While empty: not possible, because the pop is gated by dataValid.
- Error flags: sticky until clrErr. If a set and clrErr land in the same cycle, set wins.
- busy is 1 in RECV and CHECK.

Optional Feature:
PS2_TIMEOUT_EN
- Defined: in RECV, if the idle counter reaches TIMEOUT_CYCLES-1 with no fe, then on the next edge the FSM goes to IDLE, the partial frame is discarded and frameError is set. The counter is ceil(log2(TIMEOUT_CYCLES)) bits wide.
- Undefined: no counter is synthesized and RECV waits indefinitely for edges. The TIMEOUT_CYCLES parameter is accepted but unused.

Test Plan:
- Frame 0x1C with parity 0 and stop 1, 10 kHz ps2Clk -> dataValid=1 and data=0x1C 2 cycles after the stop-bit fe; one rdStrobe gives dataValid=0 and data=0x00; no error flags set.
- Frames 0xF0 (parity 1) then 0x1C back-to-back, no reads -> head reads 0xF0, then 0x1C after a pop; order is preserved.
- Frame 0x1C with parity 1 -> parityError=1, dataValid stays 0; clrErr pulse -> parityError=0.
- Five good frames 0x01..0x05 with FIFO_DEPTH=4 and no reads -> overflow=1; popping gives 0x01..0x04, then dataValid=0.
- PS2_TIMEOUT_EN with TIMEOUT_CYCLES=1000: send start plus 4 bits, then hold ps2Clk high -> 1000 cycles after the last fe, busy=0 and frameError=1. A following good frame 0x5A is received correctly.
- reset asserted for 1 cycle after bit 5 of a frame -> all outputs 0 immediately. The frame remainder (with ps2Data=0 at the next fe) is treated as a new start bit; when it is misaligned this ends in an error flag or a wrong byte, never a hang.
